// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-requester Wishbone arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle; master drives the request side, slave the response side.
interface wshb_if #(
    parameter int DATA_BYTES = 4
) ();

    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [31:0]             adr;
    logic [DATA_BYTES-1:0]   sel;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic [2:0]              cti;
    logic [1:0]              bte;

    modport master (
        output cyc, stb, we, adr, sel, dat_ms, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/wshb_arb_rr.sv
// Two-way grant FSM: holds the owner while its cyc stays high, hands over
// directly on release, and breaks ties by fixed priority or round-robin.
module wshb_arb_rr
    import wshb_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output arb_state_t state_o,
    output logic [1:0] gnt_o
);

    arb_state_t state_q, state_d;
    logic       last_srv_q, last_srv_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_srv_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_srv_q <= last_srv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i == 2'b11) begin
                    // Round-robin favours whoever was not served last.
                    state_d = (FIXED_PRIO || last_srv_q) ? GNT0 : GNT1;
                end else if (req_i[0]) begin
                    state_d = GNT0;
                end else if (req_i[1]) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!req_i[0]) begin
                    state_d = req_i[1] ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!req_i[1]) begin
                    state_d = req_i[0] ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_srv_d = last_srv_q;
        if (state_d == GNT0) begin
            last_srv_d = 1'b0;
        end else if (state_d == GNT1) begin
            last_srv_d = 1'b1;
        end
    end

    assign state_o = state_q;
    assign gnt_o   = {state_q == GNT1, state_q == GNT0};

endmodule

// File: rtl/wshb_arbiter.sv
// Shares one Wishbone slave between two masters; the grant FSM lives in
// wshb_arb_rr, this level only steers the bus signals from the registered state.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] gnt
);

    arb_state_t state;

    wshb_arb_rr #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   ({wshb_ifs1.cyc, wshb_ifs0.cyc}),
        .state_o (state),
        .gnt_o   (gnt)
    );

    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = 32'd0;
        wshb_ifm.sel    = {DATA_BYTES{1'b0}};
        wshb_ifm.dat_ms = {(8*DATA_BYTES){1'b0}};
        wshb_ifm.cti    = CTI_CLASSIC;
        wshb_ifm.bte    = 2'b00;
        case (state)
            GNT0: begin
                wshb_ifm.cyc    = wshb_ifs0.cyc;
                wshb_ifm.stb    = wshb_ifs0.stb;
                wshb_ifm.we     = wshb_ifs0.we;
                wshb_ifm.adr    = wshb_ifs0.adr;
                wshb_ifm.sel    = wshb_ifs0.sel;
                wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
                wshb_ifm.cti    = wshb_ifs0.cti;
                wshb_ifm.bte    = wshb_ifs0.bte;
            end
            GNT1: begin
                wshb_ifm.cyc    = wshb_ifs1.cyc;
                wshb_ifm.stb    = wshb_ifs1.stb;
                wshb_ifm.we     = wshb_ifs1.we;
                wshb_ifm.adr    = wshb_ifs1.adr;
                wshb_ifm.sel    = wshb_ifs1.sel;
                wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
                wshb_ifm.cti    = wshb_ifs1.cti;
                wshb_ifm.bte    = wshb_ifs1.bte;
            end
            default: ;
        endcase
    end

    // Responses follow the current owner, so an ack in its final cycle still lands.
    always_comb begin
        wshb_ifs0.ack    = (state == GNT0) && wshb_ifm.ack;
        wshb_ifs0.err    = (state == GNT0) && wshb_ifm.err;
        wshb_ifs0.rty    = (state == GNT0) && wshb_ifm.rty;
        wshb_ifs1.ack    = (state == GNT1) && wshb_ifm.ack;
        wshb_ifs1.err    = (state == GNT1) && wshb_ifm.err;
        wshb_ifs1.rty    = (state == GNT1) && wshb_ifm.rty;
        wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
        wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
    end

endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-requester Wishbone arbiter that shares one Wishbone slave (the SDRAM controller port) between two masters of the graphics controller.
- Typical pairing: master 0 = video frame reader, master 1 = frame writer / pattern generator.
- Sits between the masters' wshb_if instances and the single slave-side wshb_if.
- Ownership is granted per bus cycle: a grant is held for as long as the owner keeps cyc asserted.

Parameters:
- DATA_BYTES, 4, data width in bytes of all three wshb_if instances. Must match the connected interfaces.
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = master 0 always wins a contest.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- wshb_ifs0  interface  wshb_if.slave  requester 0; master 0 connects here.
- wshb_ifs1  interface  wshb_if.slave  requester 1; master 1 connects here.
- wshb_ifm  interface  wshb_if.master  shared downstream bus to the slave.
- gnt  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle. Debug and verification only.

Behaviour:
- Requests: req0 = wshb_ifs0.cyc, req1 = wshb_ifs1.cyc.
- FSM states: IDLE, GNT0, GNT1. Registered state; gnt decodes directly from the state.
- Register last_srv (1 bit) records the most recently granted master.
- Reset when rst=1 at a clock edge:
  - state <= IDLE, last_srv <= 1, so master 0 wins the first contest.
  - Reset is honoured mid-transaction: the downstream bus drops in the cycle after reset is sampled.
- IDLE transitions:
  - req0 only -> GNT0; req1 only -> GNT1.
  - Both requesting:
    - FIXED_PRIO=1 -> GNT0.
    - FIXED_PRIO=0 -> the master != last_srv.
  - No request -> stay IDLE.
- GNTx transitions:
  - Stay while reqx = 1.
  - When reqx = 0 and the other master is requesting -> go directly to GNTy (no idle cycle).
  - Otherwise -> IDLE.
  - last_srv is updated on every entry into GNTx.
- Arbitration latency:
  - A request seen in IDLE at edge N is granted from cycle N+1.
  - The earliest downstream stb is the cycle after cyc rises.
  - Masters must tolerate this; Wishbone classic permits it.
- Downstream mux (combinational from state):
  - In GNTx, wshb_ifm.{cyc, stb, we, adr, sel, dat_ms, cti, bte} = wshb_ifsx.{...}.
  - In IDLE: cyc = 0, stb = 0, we = 0, adr = 0, sel = 0, dat_ms = 0, cti = 3'b000, bte = 2'b00.
- Upstream routing:
  - ack, err and rty go only to the owner. The non-owner sees ack = err = rty = 0 at all times.
  - dat_sm is broadcast unmodified to both masters.
- Pre-emption:
  - None. A master holding cyc keeps the grant indefinitely, including across bursts (cti = 3'b010).
  - Starvation bound is therefore the owner's cyc length; fairness applies only at cycle boundaries.
- Simultaneous events:
  - Owner drops cyc in the same cycle the other master raises cyc -> handover at that edge.
  - An ack arriving in the owner's last cyc cycle is still routed to that owner (the mux follows the current state, not the next).
- No combinational path from the masters' stb to the grant decision. The grant depends only on registered state and cyc sampled at the edge.
- dat_sm is 8*DATA_BYTES bits wide; adr is 32 bits; no width conversion is performed.

Decomposition:
- Shared package wshb_arb_pkg:
  - Enum arb_state_t {IDLE, GNT0, GNT1}.
  - Constants for the Wishbone cti values CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111.
- One natural sub-module: wshb_arb_rr, a 2-way round-robin grant FSM with inputs req[1:0] and outputs state / gnt[1:0].
  - The top level holds only the signal muxes.

Test Plan:
- After rst: only m0 asserts cyc=1/stb=1, adr=32'h100, we=1; slave acks after 2 cycles -> gnt=01 one cycle later; slave sees adr 32'h100, we=1; only m0 sees ack; m1.ack stays 0.
- Both masters raise cyc in the same cycle from IDLE (round-robin mode, after reset) -> gnt=01 first. When m0 drops cyc, gnt=10 on the next edge with no IDLE cycle. A repeated contest then goes to m0 (last_srv=1).
- FIXED_PRIO=1, both requesting continuously with single transfers and cyc toggling -> m0 wins every contest that starts from IDLE.
- m1 holds an 8-beat burst (cti=010 ×7, then 111) while m0 requests -> m0 stays ungranted until m1's cyc falls; all 8 acks reach m1 only.
- rst pulsed for 1 cycle during m0's burst -> next cycle: gnt=00, downstream cyc=0/stb=0; after rst=0 with m1 requesting, m0 is granted first if still requesting (last_srv=1).
- Slave returns err=1 on m1's access with dat_sm=32'hDEADBEEF -> m1 sees err=1; m0 sees err=0 and dat_sm=32'hDEADBEEF (broadcast); the grant remains with m1 until m1 drops cyc.
